wb_load_unit: RTL and testbench
===============================

# wb_load_unit

Stage-3 write-back and load unit of the STRV32I core. It takes the registered execute-stage fields (write-back select, load size/sign, destination, address and result candidates) and drives the register-file write port. For loads it acts as the initiator on the data-memory read interface: it issues a word-aligned request, waits for the grant and the response, then aligns and extends the returned data. Upstream stages are stalled until the load data is captured.

## Interface
- No parameters; widths are fixed at XLEN=32.
- clk_in  input  1  core clock, all state on rising edge
- rst_n_in  input  1  asynchronous active-low reset
- wb_mux_sel_in  input  3  write-back source select (package encoding)
- load_size_in  input  2  00 byte, 01 half, 10 word, 11 treated as word
- load_unsigned_in  input  1  1 = zero-extend, 0 = sign-extend
- rf_wr_en_in  input  1  instruction writes rd
- rd_addr_in  input  5  destination register
- iadder_in  input  32  load address / AUIPC result
- alu_result_in  input  32  ALU result
- imm_in  input  32  LUI immediate
- pc_plus_4_in  input  32  link value
- csr_data_in  input  32  CSR read data
- dmem_req_out  output  1  read request, held until granted
- dmem_addr_out  output  32  {iadder_in[31:2],2'b00}
- dmem_gnt_in  input  1  request accepted this cycle
- dmem_rvalid_in  input  1  read data valid
- dmem_rdata_in  input  32  read data word
- stall_out  output  1  hold all upstream pipeline registers
- rf_wr_en_out  output  1  register-file write strobe
- rf_rd_addr_out  output  5  register-file write address
- rf_wr_data_out  output  32  register-file write data
- misaligned_out  output  1  present only with LOAD_MISALIGN_TRAP_EN

## Operation
- Load = rf_wr_en_in && wb_mux_sel_in==WB_SEL_LOAD. Other selects: ALU 0, LOAD 1, IMM 2, IADDER 3, CSR 4, PC4 5; 6/7 route alu_result_in.
- FSM states: IDLE, REQ, WAIT.
- IDLE: non-load -> register write-back next cycle and stay in IDLE; load -> REQ, stall_out=1.
- REQ: dmem_req_out=1, stall_out=1; dmem_gnt_in -> WAIT.
- WAIT: stall_out = !dmem_rvalid_in; on rvalid, register aligned data, rf_wr_en_out=1 next cycle, -> IDLE.
- Alignment, off=iadder_in[1:0]: byte = rdata[8*off+:8]; half = rdata[16*off[1]+:16]; word = rdata. Extend to 32 bits per load_unsigned_in.
- rf_wr_en_out is forced 0 when rd_addr_in==0.
- dmem_addr_out is combinational from iadder_in; upstream holds iadder_in stable while stall_out=1.
- dmem_rvalid_in outside WAIT is ignored.

## Timing
- Reset values: state IDLE; dmem_req_out, rf_wr_en_out, rf_rd_addr_out, rf_wr_data_out, misaligned_out all 0.
- stall_out is combinational from state and inputs; in IDLE under reset it is 0.
- Non-load latency: 1 cycle from input to rf_wr_*.
- Load minimum: cycle 0 present (stall), cycle 1 REQ with gnt (stall), cycle 2 WAIT with rvalid (stall=0), cycle 3 rf write. The next instruction is accepted in cycle 3.
- Gnt and rvalid never in the same cycle; rvalid arrives at the earliest one cycle after gnt.
- A reset during REQ or WAIT aborts the load: no write, no request after release.
- rf_wr_en_out is a one-cycle pulse per instruction; it is never asserted while in REQ or WAIT.

## Configuration
- LOAD_MISALIGN_TRAP_EN defined:
  - A half load with off[0]=1, or a word load with off!=0, issues no request and no rf write.
  - misaligned_out pulses 1 for one cycle after presentation; no stall.
- LOAD_MISALIGN_TRAP_EN undefined:
  - The port is absent.
  - Misaligned offsets are silently truncated per the alignment rules.

## Structure
- Package strv32i_pkg holds:
  - WB_SEL_* constants
  - LOAD_SIZE_* constants
  - the wb_state_t enum {IDLE, REQ, WAIT}
- Sub-module load_align: combinational extractor with inputs rdata, offset, size and unsigned, and output data32.
- The FSM and the write-back mux stay in the top module.

## Test plan
- ALU write: sel=0, rd=5, alu=0x1234 -> next cycle rf_wr_en=1, addr=5, data=0x1234, stall=0.
- Signed byte load: addr 0x103, rdata 0x80FFFFFF, gnt in REQ, rvalid next cycle -> data 0xFFFFFF80; stall high 2 cycles; write in cycle 3.
- Unsigned half load: addr 0x102, rdata 0xBEEF0000, unsigned -> data 0x0000BEEF. Gnt delayed 3 cycles -> req held, stall held.
- rd=0 load: completes the bus handshake with rf_wr_en_out=0 throughout.
- Reset in WAIT: rst_n_in low then high, stray rvalid -> no write, state IDLE, req=0.
- With LOAD_MISALIGN_TRAP_EN: word load at 0x102 -> misaligned_out=1 for 1 cycle, dmem_req_out=0, no write.

Source files
------------

// File: rtl/strv32i_pkg.sv
// Shared STRV32I write-back definitions: source selects, load sizes and the
// load-unit state encoding.
package strv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] WB_SEL_ALU    = 3'd0;
    localparam logic [2:0] WB_SEL_LOAD   = 3'd1;
    localparam logic [2:0] WB_SEL_IMM    = 3'd2;
    localparam logic [2:0] WB_SEL_IADDER = 3'd3;
    localparam logic [2:0] WB_SEL_CSR    = 3'd4;
    localparam logic [2:0] WB_SEL_PC4    = 3'd5;

    localparam logic [1:0] LOAD_SIZE_BYTE = 2'b00;
    localparam logic [1:0] LOAD_SIZE_HALF = 2'b01;
    localparam logic [1:0] LOAD_SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } wb_state_t;

    // Size 2'b11 behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            LOAD_SIZE_BYTE: return 1'b0;
            LOAD_SIZE_HALF: return off[0];
            default:        return (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/wb_load_unit_load_align.sv
// Load data extractor: picks the addressed byte/half out of the returned word
// and sign- or zero-extends it to XLEN.
module load_align
    import strv32i_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      offset_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    output logic [XLEN-1:0] data32_o
);

    logic [7:0]  byte_w;
    logic [15:0] half_w;

    always_comb begin
        byte_w = rdata_i[7:0];
        case (offset_i)
            2'd0: byte_w = rdata_i[7:0];
            2'd1: byte_w = rdata_i[15:8];
            2'd2: byte_w = rdata_i[23:16];
            2'd3: byte_w = rdata_i[31:24];
            default: byte_w = rdata_i[7:0];
        endcase
    end

    // Halfword offsets ignore bit 0; an odd offset lands in the enclosing half.
    assign half_w = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        data32_o = rdata_i;
        case (size_i)
            LOAD_SIZE_BYTE: data32_o = {{24{~unsigned_i & byte_w[7]}}, byte_w};
            LOAD_SIZE_HALF: data32_o = {{16{~unsigned_i & half_w[15]}}, half_w};
            default:        data32_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/wb_load_unit.sv
// STRV32I stage-3 write-back and data-memory load unit.
// Optional build macro: LOAD_MISALIGN_TRAP_EN (adds misaligned_out, suppresses misaligned loads).
module wb_load_unit
    import strv32i_pkg::*;
(
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic [2:0]      wb_mux_sel_in,
    input  logic [1:0]      load_size_in,
    input  logic            load_unsigned_in,
    input  logic            rf_wr_en_in,
    input  logic [4:0]      rd_addr_in,
    input  logic [XLEN-1:0] iadder_in,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic [XLEN-1:0] pc_plus_4_in,
    input  logic [XLEN-1:0] csr_data_in,
    output logic            dmem_req_out,
    output logic [XLEN-1:0] dmem_addr_out,
    input  logic            dmem_gnt_in,
    input  logic            dmem_rvalid_in,
    input  logic [XLEN-1:0] dmem_rdata_in,
    output logic            stall_out,
    output logic            rf_wr_en_out,
    output logic [4:0]      rf_rd_addr_out,
    output logic [XLEN-1:0] rf_wr_data_out
`ifdef LOAD_MISALIGN_TRAP_EN
    ,
    output logic            misaligned_out
`endif
);

    wb_state_t       state_q;
    logic            req_q;
    logic            wr_en_q;
    logic [4:0]      rd_addr_q;
    logic [XLEN-1:0] wr_data_q;

    logic            is_load;
    logic            misalign;
    logic            start_load;
    logic            rd_nonzero;
    logic [XLEN-1:0] wb_data;
    logic [XLEN-1:0] load_data;

    assign is_load    = rf_wr_en_in && (wb_mux_sel_in == WB_SEL_LOAD);
    assign rd_nonzero = (rd_addr_in != 5'd0);

`ifdef LOAD_MISALIGN_TRAP_EN
    logic mis_q;
    assign misalign       = is_misaligned(load_size_in, iadder_in[1:0]);
    assign misaligned_out = mis_q;
`else
    assign misalign = 1'b0;
`endif

    assign start_load    = is_load && !misalign;
    assign dmem_addr_out = {iadder_in[XLEN-1:2], 2'b00};
    assign dmem_req_out  = req_q;

    assign rf_wr_en_out   = wr_en_q;
    assign rf_rd_addr_out = rd_addr_q;
    assign rf_wr_data_out = wr_data_q;

    load_align u_align (
        .rdata_i    (dmem_rdata_in),
        .offset_i   (iadder_in[1:0]),
        .size_i     (load_size_in),
        .unsigned_i (load_unsigned_in),
        .data32_o   (load_data)
    );

    always_comb begin
        wb_data = alu_result_in;
        case (wb_mux_sel_in)
            WB_SEL_IMM:    wb_data = imm_in;
            WB_SEL_IADDER: wb_data = iadder_in;
            WB_SEL_CSR:    wb_data = csr_data_in;
            WB_SEL_PC4:    wb_data = pc_plus_4_in;
            default:       wb_data = alu_result_in;
        endcase
    end

    // Stall releases in the rvalid cycle so the next instruction lands right after the write.
    always_comb begin
        stall_out = 1'b0;
        if (rst_n_in) begin
            case (state_q)
                IDLE:    stall_out = start_load;
                REQ:     stall_out = 1'b1;
                WAIT:    stall_out = !dmem_rvalid_in;
                default: stall_out = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_addr_q <= 5'd0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_load) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                    end else if (!is_load) begin
                        wr_en_q   <= rf_wr_en_in && rd_nonzero;
                        rd_addr_q <= rd_addr_in;
                        wr_data_q <= wb_data;
                    end
                end
                REQ: begin
                    if (dmem_gnt_in) begin
                        state_q <= WAIT;
                        req_q   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid_in) begin
                        state_q   <= IDLE;
                        wr_en_q   <= rd_nonzero;
                        rd_addr_q <= rd_addr_in;
                        wr_data_q <= load_data;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef LOAD_MISALIGN_TRAP_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= (state_q == IDLE) && is_load && misalign;
        end
    end
`endif

endmodule

// File: tb/tb_wb_load_unit.sv
// Directed bench for wb_load_unit: per-cycle comparison against a behavioural
// model of write-back values, load extraction and handshake timing.
module tb_wb_load_unit;
    import strv32i_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [2:0]  wb_mux_sel_in;
    logic [1:0]  load_size_in;
    logic        load_unsigned_in;
    logic        rf_wr_en_in;
    logic [4:0]  rd_addr_in;
    logic [31:0] iadder_in, alu_result_in, imm_in, pc_plus_4_in, csr_data_in;
    logic        dmem_req_out;
    logic [31:0] dmem_addr_out;
    logic        dmem_gnt_in, dmem_rvalid_in;
    logic [31:0] dmem_rdata_in;
    logic        stall_out, rf_wr_en_out;
    logic [4:0]  rf_rd_addr_out;
    logic [31:0] rf_wr_data_out;
`ifdef LOAD_MISALIGN_TRAP_EN
    logic        misaligned_out;
`endif

    always #5 clk_in = ~clk_in;

    wb_load_unit dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .wb_mux_sel_in(wb_mux_sel_in), .load_size_in(load_size_in),
        .load_unsigned_in(load_unsigned_in), .rf_wr_en_in(rf_wr_en_in),
        .rd_addr_in(rd_addr_in), .iadder_in(iadder_in),
        .alu_result_in(alu_result_in), .imm_in(imm_in),
        .pc_plus_4_in(pc_plus_4_in), .csr_data_in(csr_data_in),
        .dmem_req_out(dmem_req_out), .dmem_addr_out(dmem_addr_out),
        .dmem_gnt_in(dmem_gnt_in), .dmem_rvalid_in(dmem_rvalid_in),
        .dmem_rdata_in(dmem_rdata_in), .stall_out(stall_out),
        .rf_wr_en_out(rf_wr_en_out), .rf_rd_addr_out(rf_rd_addr_out),
        .rf_wr_data_out(rf_wr_data_out)
`ifdef LOAD_MISALIGN_TRAP_EN
        , .misaligned_out(misaligned_out)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic        chk_en = 1'b0;
    logic        exp_stall, exp_req, exp_wen, exp_mis;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic        nxt_wen, nxt_mis;
    logic [4:0]  nxt_rd;
    logic [31:0] nxt_data;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_wb(input logic [2:0] sel, input logic [31:0] alu,
            input logic [31:0] imm, input logic [31:0] iadder, input logic [31:0] pc4,
            input logic [31:0] csr);
        case (sel)
            3'd2:    return imm;
            3'd3:    return iadder;
            3'd4:    return csr;
            3'd5:    return pc4;
            default: return alu;
        endcase
    endfunction

    // Shift the addressed lane down, mask to its width, then extend.
    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
            input logic [1:0] size, input logic uns);
        int          off;
        int          nbytes;
        logic [31:0] mask;
        logic [31:0] val;
        off = int'(addr % 4);
        if (size == 2'd0) begin
            nbytes = 1;
        end else if (size == 2'd1) begin
            nbytes = 2;
            off = (off / 2) * 2;
        end else begin
            nbytes = 4;
            off = 0;
        end
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
        val = (rdata >> (8 * off)) & mask;
        if (!uns && val[8 * nbytes - 1]) val = val | ~mask;
        return val;
    endfunction

    always @(negedge clk_in) begin
        if (chk_en) begin
            check32("stall", {31'b0, stall_out}, {31'b0, exp_stall});
            check32("dmem_req", {31'b0, dmem_req_out}, {31'b0, exp_req});
            check32("rf_wr_en", {31'b0, rf_wr_en_out}, {31'b0, exp_wen});
            check32("dmem_addr", dmem_addr_out, iadder_in & ~32'h3);
            if (exp_wen) begin
                check32("rf_rd_addr", {27'b0, rf_rd_addr_out}, {27'b0, exp_rd});
                check32("rf_wr_data", rf_wr_data_out, exp_data);
            end
`ifdef LOAD_MISALIGN_TRAP_EN
            check32("misaligned", {31'b0, misaligned_out}, {31'b0, exp_mis});
`endif
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
        exp_wen  = nxt_wen;
        exp_rd   = nxt_rd;
        exp_data = nxt_data;
        exp_mis  = nxt_mis;
        nxt_wen  = 1'b0;
        nxt_mis  = 1'b0;
    endtask

    task automatic idle_inputs();
        wb_mux_sel_in  = WB_SEL_ALU;
        rf_wr_en_in    = 1'b0;
        rd_addr_in     = 5'd0;
        dmem_gnt_in    = 1'b0;
        dmem_rvalid_in = 1'b0;
        exp_stall      = 1'b0;
        exp_req        = 1'b0;
    endtask

    task automatic do_wb(input logic [2:0] sel, input logic [4:0] rd, input logic we,
            input logic [31:0] alu, input logic [31:0] imm, input logic [31:0] iadder,
            input logic [31:0] pc4, input logic [31:0] csr);
        step();
        idle_inputs();
        wb_mux_sel_in = sel; rf_wr_en_in = we; rd_addr_in = rd;
        alu_result_in = alu; imm_in = imm; iadder_in = iadder;
        pc_plus_4_in = pc4; csr_data_in = csr;
        nxt_wen  = we && (rd != 5'd0);
        nxt_rd   = rd;
        nxt_data = model_wb(sel, alu, imm, iadder, pc4, csr);
    endtask

    task automatic do_load(input logic [4:0] rd, input logic [31:0] addr, input logic [1:0] size,
            input logic uns, input logic [31:0] rdata, input int gnt_dly, input int rv_dly,
            input logic [31:0] lit);
        step();
        idle_inputs();
        wb_mux_sel_in = WB_SEL_LOAD; rf_wr_en_in = 1'b1; rd_addr_in = rd;
        iadder_in = addr; load_size_in = size; load_unsigned_in = uns;
        exp_stall = 1'b1;
        repeat (gnt_dly) begin
            step();
            exp_stall = 1'b1; exp_req = 1'b1;
        end
        step();
        dmem_gnt_in = 1'b1;
        exp_stall = 1'b1; exp_req = 1'b1;
        repeat (rv_dly) begin
            step();
            dmem_gnt_in = 1'b0;
            exp_stall = 1'b1; exp_req = 1'b0;
        end
        step();
        dmem_gnt_in = 1'b0; dmem_rvalid_in = 1'b1; dmem_rdata_in = rdata;
        exp_stall = 1'b0; exp_req = 1'b0;
        nxt_wen  = (rd != 5'd0);
        nxt_rd   = rd;
        nxt_data = model_load(rdata, addr, size, uns);
        check32("model_pin", nxt_data, lit);
    endtask

    initial begin
        rst_n_in = 1'b0;
        idle_inputs();
        load_size_in = 2'd0; load_unsigned_in = 1'b0;
        iadder_in = 32'h0; alu_result_in = 32'h0; imm_in = 32'h0;
        pc_plus_4_in = 32'h0; csr_data_in = 32'h0; dmem_rdata_in = 32'h0;
        exp_wen = 1'b0; exp_rd = 5'd0; exp_data = 32'h0; exp_mis = 1'b0;
        nxt_wen = 1'b0; nxt_rd = 5'd0; nxt_data = 32'h0; nxt_mis = 1'b0;
        chk_en = 1'b1;

        // Load presented while reset is still asserted must not stall.
        step();
        wb_mux_sel_in = WB_SEL_LOAD; rf_wr_en_in = 1'b1; rd_addr_in = 5'd3;
        iadder_in = 32'h0000_0104; load_size_in = LOAD_SIZE_WORD;
        #3;
        check32("reset_rd_addr", {27'b0, rf_rd_addr_out}, 32'h0);
        check32("reset_wr_data", rf_wr_data_out, 32'h0);
        step();
        rst_n_in = 1'b1;
        idle_inputs();

        do_wb(3'd0, 5'd5, 1'b1, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        idle_inputs();
        #3;
        check32("alu_literal", rf_wr_data_out, 32'h0000_1234);

        do_wb(3'd2, 5'd6, 1'b1, 32'h1, 32'hABCD_E000, 32'h2, 32'h3, 32'h4);
        do_wb(3'd3, 5'd7, 1'b1, 32'h1, 32'h2, 32'h0000_2468, 32'h3, 32'h4);
        do_wb(3'd4, 5'd8, 1'b1, 32'h1, 32'h2, 32'h3, 32'h4, 32'hC5C5_0001);
        do_wb(3'd5, 5'd9, 1'b1, 32'h1, 32'h2, 32'h3, 32'h0000_0404, 32'h4);
        do_wb(3'd6, 5'd10, 1'b1, 32'h7777_0000, 32'h2, 32'h3, 32'h4, 32'h5);
        do_wb(3'd7, 5'd31, 1'b1, 32'h0BAD_F00D, 32'h2, 32'h3, 32'h4, 32'h5);
        do_wb(3'd0, 5'd0, 1'b1, 32'hFFFF_FFFF, 32'h2, 32'h3, 32'h4, 32'h5);
        do_wb(3'd0, 5'd12, 1'b0, 32'h1111_1111, 32'h2, 32'h3, 32'h4, 32'h5);
        do_wb(3'd1, 5'd12, 1'b0, 32'h1111_1111, 32'h2, 32'h3, 32'h4, 32'h5);

        do_load(5'd4, 32'h0000_0103, LOAD_SIZE_BYTE, 1'b0, 32'h80FF_FFFF, 0, 0, 32'hFFFF_FF80);
        do_wb(3'd0, 5'd11, 1'b1, 32'h0000_00AA, 32'h0, 32'h0, 32'h0, 32'h0);
        do_load(5'd13, 32'h0000_0102, LOAD_SIZE_HALF, 1'b1, 32'hBEEF_0000, 3, 1, 32'h0000_BEEF);
        do_load(5'd0, 32'h0000_0100, LOAD_SIZE_WORD, 1'b0, 32'hDEAD_BEEF, 1, 2, 32'hDEAD_BEEF);
        do_load(5'd14, 32'h0000_0201, LOAD_SIZE_BYTE, 1'b1, 32'h0000_9A00, 0, 1, 32'h0000_009A);
        do_load(5'd15, 32'h0000_0300, LOAD_SIZE_HALF, 1'b0, 32'h0000_8001, 2, 0, 32'hFFFF_8001);
        do_load(5'd16, 32'h0000_0404, 2'b11, 1'b0, 32'h1357_9BDF, 0, 0, 32'h1357_9BDF);
`ifdef LOAD_MISALIGN_TRAP_EN
        step();
        idle_inputs();
        wb_mux_sel_in = WB_SEL_LOAD; rf_wr_en_in = 1'b1; rd_addr_in = 5'd17;
        iadder_in = 32'h0000_0102; load_size_in = LOAD_SIZE_WORD;
        nxt_mis = 1'b1;
        step();
        idle_inputs();
        step();
        idle_inputs();
`else
        do_load(5'd17, 32'h0000_0103, LOAD_SIZE_HALF, 1'b0, 32'h1234_ABCD, 0, 0, 32'h0000_1234);
        do_load(5'd18, 32'h0000_0102, LOAD_SIZE_WORD, 1'b0, 32'hCAFE_0001, 0, 0, 32'hCAFE_0001);
`endif

        // Reset while waiting for read data aborts the load.
        step();
        idle_inputs();
        wb_mux_sel_in = WB_SEL_LOAD; rf_wr_en_in = 1'b1; rd_addr_in = 5'd7;
        iadder_in = 32'h0000_0200; load_size_in = LOAD_SIZE_WORD;
        exp_stall = 1'b1;
        step();
        dmem_gnt_in = 1'b1;
        exp_stall = 1'b1; exp_req = 1'b1;
        step();
        dmem_gnt_in = 1'b0;
        exp_stall = 1'b1; exp_req = 1'b0;
        step();
        rst_n_in = 1'b0;
        exp_stall = 1'b0; exp_req = 1'b0;
        step();
        rst_n_in = 1'b1;
        idle_inputs();
        dmem_rvalid_in = 1'b1; dmem_rdata_in = 32'h5555_AAAA;
        step();
        idle_inputs();
        step();
        idle_inputs();
        #3;
        check32("post_reset_req", {31'b0, dmem_req_out}, 32'h0);

        do_wb(3'd0, 5'd20, 1'b1, 32'h0000_0F0F, 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        idle_inputs();
        step();
        idle_inputs();
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
